// File: rtl/trig_cap_pkg.sv
// Shared types and default sizes for the trigger capture controller.
package trig_cap_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_NUM_CH = 5;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POSTTRIG,
    DONE
  } cap_state_t;

endpackage

// File: rtl/cap_addr_cnt.sv
// Wrap-around sample-RAM write address counter with synchronous clear.
module cap_addr_cnt #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_q;

  // Natural overflow gives the DEPTH-1 -> 0 wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) addr_q <= '0;
    else if (inc)   addr_q <= addr_q + ADDR_W'(1);
  end

  assign addr = addr_q;

endmodule

// File: rtl/trig_capture_ctrl.sv
// Capture sequencer: pre-trigger fill, armed wait, post-trigger count, done.
module trig_capture_ctrl
  import trig_cap_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              stop,
  input  logic              smpl_en,
  input  logic [NUM_CH-1:0] chan_trig,
  input  logic              prot_trig,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              armed,
  output logic              triggered,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              capture_done,
  output cap_state_t        dbg_state
);

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pre_need_q, pre_need_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              tsmp_q, tsmp_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;
  logic              addr_clr;
  logic              trig_in;
  logic              active;
  logic [ADDR_W-1:0] pre_inc;
  logic [ADDR_W-1:0] post_nxt;

  assign trig_in  = (&chan_trig) & prot_trig;
  assign active   = (state_q == PRETRIG) || (state_q == ARMED) || (state_q == POSTTRIG);
  assign we       = smpl_en & active;
  assign pre_inc  = pre_cnt_q + ADDR_W'(1);
  // tsmp_q marks that the trigger sample itself has been written.
  assign post_nxt = tsmp_q ? (post_cnt_q + ADDR_W'(1)) : '0;

  cap_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (addr_clr),
    .inc  (we),
    .addr (waddr)
  );

  always_comb begin
    state_d     = state_q;
    pre_need_d  = pre_need_q;
    pos_d       = pos_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    tsmp_d      = tsmp_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    addr_clr    = 1'b0;
    if (stop) begin
      state_d     = IDLE;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (run) begin
            state_d     = PRETRIG;
            addr_clr    = 1'b1;
            pre_cnt_d   = '0;
            post_cnt_d  = '0;
            tsmp_d      = 1'b0;
            triggered_d = 1'b0;
            done_d      = 1'b0;
            // trig_pos is ADDR_W bits wide, so it never exceeds DEPTH-1.
            pos_d       = trig_pos;
            pre_need_d  = {ADDR_W{1'b1}} - trig_pos;
          end
        end
        PRETRIG: begin
          if (pre_need_q == '0) begin
            state_d = ARMED;
          end else if (we) begin
            pre_cnt_d = pre_inc;
            if (pre_inc == pre_need_q) state_d = ARMED;
          end
        end
        ARMED: begin
          if (trig_in) begin
            triggered_d = 1'b1;
            state_d     = POSTTRIG;
          end
        end
        POSTTRIG: begin
          if (we) begin
            if (!tsmp_q) begin
              trig_addr_d = waddr;
              tsmp_d      = 1'b1;
            end
            post_cnt_d = post_nxt;
            if (post_nxt == pos_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pre_need_q  <= '0;
      pos_q       <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      tsmp_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_need_q  <= pre_need_d;
      pos_q       <= pos_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      tsmp_q      <= tsmp_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  assign armed        = (state_q == ARMED);
  assign triggered    = triggered_q;
  assign trig_addr    = trig_addr_q;
  assign capture_done = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Directed bench for trig_capture_ctrl with a 16-entry sample RAM.
module tb_trig_capture_ctrl;
  import trig_cap_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, run, stop, smpl_en, prot_trig;
  logic [4:0]    chan_trig;
  logic [AW-1:0] trig_pos;
  logic          armed, triggered, we, capture_done;
  logic [AW-1:0] waddr, trig_addr;
  cap_state_t    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trig_capture_ctrl #(.ADDR_W(AW), .NUM_CH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .stop         (stop),
    .smpl_en      (smpl_en),
    .chan_trig    (chan_trig),
    .prot_trig    (prot_trig),
    .trig_pos     (trig_pos),
    .armed        (armed),
    .triggered    (triggered),
    .we           (we),
    .waddr        (waddr),
    .trig_addr    (trig_addr),
    .capture_done (capture_done),
    .dbg_state    (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run       = 1'($urandom_range(0, 1));
      stop      = 1'($urandom_range(0, 1));
      smpl_en   = 1'($urandom_range(0, 1));
      chan_trig = 5'($urandom_range(0, 31));
      prot_trig = 1'($urandom_range(0, 1));
      trig_pos  = AW'($urandom_range(0, 15));
      step();
    end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    n_checks++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed got=%b exp=0", armed); end
    n_checks++; if (triggered !== 1'b0) begin n_fail++; $display("FAIL reset_triggered got=%b exp=0", triggered); end
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", we); end
    n_checks++; if (waddr !== 4'd0) begin n_fail++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
    n_checks++; if (trig_addr !== 4'd0) begin n_fail++; $display("FAIL reset_trig_addr got=%0d exp=0", trig_addr); end
    n_checks++; if (capture_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", capture_done); end
    run = 0; stop = 0; smpl_en = 0; chan_trig = 5'h1F; prot_trig = 1; trig_pos = 0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_normal();
    int nw;
    int guard;
    trig_pos = 4'd5; smpl_en = 1'b1; run = 1'b1;
    step();
    run = 1'b0;
    n_checks++; if (dbg_state !== PRETRIG) begin n_fail++; $display("FAIL norm_pretrig got=%0d exp=%0d", dbg_state, PRETRIG); end
    nw = 0; guard = 0;
    while (dbg_state == PRETRIG && guard < 64) begin
      if (we) begin
        n_checks++; if (waddr !== AW'(nw)) begin n_fail++; $display("FAIL norm_pre_addr got=%0d exp=%0d", waddr, nw); end
        nw++;
      end
      step(); guard++;
    end
    n_checks++; if (nw != 10) begin n_fail++; $display("FAIL norm_pre_writes got=%0d exp=10", nw); end
    n_checks++; if (armed !== 1'b1) begin n_fail++; $display("FAIL norm_armed got=%b exp=1", armed); end
    n_checks++; if (waddr !== 4'd10) begin n_fail++; $display("FAIL norm_armed_addr got=%0d exp=10", waddr); end
    step();
    n_checks++; if (triggered !== 1'b1) begin n_fail++; $display("FAIL norm_triggered got=%b exp=1", triggered); end
    n_checks++; if (armed !== 1'b0) begin n_fail++; $display("FAIL norm_disarm got=%b exp=0", armed); end
    nw = 0; guard = 0;
    while (dbg_state == POSTTRIG && guard < 64) begin
      if (we) nw++;
      step(); guard++;
    end
    n_checks++; if (nw != 6) begin n_fail++; $display("FAIL norm_post_writes got=%0d exp=6", nw); end
    n_checks++; if (trig_addr !== 4'd11) begin n_fail++; $display("FAIL norm_trig_addr got=%0d exp=11", trig_addr); end
    n_checks++; if (capture_done !== 1'b1) begin n_fail++; $display("FAIL norm_done got=%b exp=1", capture_done); end
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL norm_done_we got=%b exp=0", we); end
    n_checks++; if (triggered !== 1'b1) begin n_fail++; $display("FAIL norm_done_trig got=%b exp=1", triggered); end
    n_checks++; if (waddr !== 4'd1) begin n_fail++; $display("FAIL norm_final_addr got=%0d exp=1", waddr); end
  endtask

  task automatic test_trig_pos0();
    int nw;
    int guard;
    trig_pos = 4'd0; smpl_en = 1'b1; run = 1'b1;
    step();
    run = 1'b0;
    n_checks++; if (capture_done !== 1'b0) begin n_fail++; $display("FAIL pos0_done_clr got=%b exp=0", capture_done); end
    n_checks++; if (triggered !== 1'b0) begin n_fail++; $display("FAIL pos0_trig_clr got=%b exp=0", triggered); end
    nw = 0; guard = 0;
    while (dbg_state == PRETRIG && guard < 64) begin
      if (we) nw++;
      step(); guard++;
    end
    n_checks++; if (nw != 15) begin n_fail++; $display("FAIL pos0_pre_writes got=%0d exp=15", nw); end
    step();
    nw = 0; guard = 0;
    while (dbg_state == POSTTRIG && guard < 64) begin
      if (we) nw++;
      step(); guard++;
    end
    n_checks++; if (nw != 1) begin n_fail++; $display("FAIL pos0_post_writes got=%0d exp=1", nw); end
    n_checks++; if (trig_addr !== 4'd0) begin n_fail++; $display("FAIL pos0_trig_addr got=%0d exp=0", trig_addr); end
    n_checks++; if (capture_done !== 1'b1) begin n_fail++; $display("FAIL pos0_done got=%b exp=1", capture_done); end
  endtask

  task automatic test_trig_pos15();
    int nw;
    int guard;
    trig_pos = 4'd15; smpl_en = 1'b1; run = 1'b1;
    step();
    run = 1'b0;
    n_checks++; if (dbg_state !== PRETRIG) begin n_fail++; $display("FAIL pos15_pretrig got=%0d exp=%0d", dbg_state, PRETRIG); end
    step();
    n_checks++; if (armed !== 1'b1) begin n_fail++; $display("FAIL pos15_armed got=%b exp=1", armed); end
    step();
    nw = 0; guard = 0;
    while (dbg_state == POSTTRIG && guard < 64) begin
      if (we) nw++;
      step(); guard++;
    end
    n_checks++; if (nw != 16) begin n_fail++; $display("FAIL pos15_post_writes got=%0d exp=16", nw); end
    n_checks++; if (trig_addr !== 4'd2) begin n_fail++; $display("FAIL pos15_trig_addr got=%0d exp=2", trig_addr); end
    n_checks++; if (capture_done !== 1'b1) begin n_fail++; $display("FAIL pos15_done got=%b exp=1", capture_done); end
  endtask

  task automatic test_pending_trigger();
    int   guard;
    logic saw_wrap;
    logic [AW-1:0] prev;
    trig_pos = 4'd3; smpl_en = 1'b1; chan_trig = 5'h1E; run = 1'b1;
    step();
    run = 1'b0;
    guard = 0;
    while (armed !== 1'b1 && guard < 64) begin step(); guard++; end
    n_checks++; if (waddr !== 4'd12) begin n_fail++; $display("FAIL pend_armed_addr got=%0d exp=12", waddr); end
    saw_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (triggered !== 1'b0 || dbg_state !== ARMED) begin
        n_checks++; n_fail++;
        $display("FAIL pend_no_trig got=%b/%0d exp=0/%0d", triggered, dbg_state, ARMED);
      end
      prev = waddr;
      step();
      if (prev == 4'd15 && waddr == 4'd0) saw_wrap = 1'b1;
    end
    n_checks++; if (saw_wrap !== 1'b1) begin n_fail++; $display("FAIL pend_wrap got=%b exp=1", saw_wrap); end
    n_checks++; if (waddr !== 4'd4) begin n_fail++; $display("FAIL pend_wait_addr got=%0d exp=4", waddr); end
    chan_trig = 5'h1F; smpl_en = 1'b0;
    step();
    n_checks++; if (triggered !== 1'b1) begin n_fail++; $display("FAIL pend_triggered got=%b exp=1", triggered); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (we !== 1'b0 || waddr !== 4'd4 || dbg_state !== POSTTRIG) begin
        n_fail++; $display("FAIL pend_hold got=%b/%0d/%0d exp=0/4/%0d", we, waddr, dbg_state, POSTTRIG);
      end
      step();
    end
    smpl_en = 1'b1;
    #1;
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL pend_strobe_we got=%b exp=1", we); end
    step();
    n_checks++; if (trig_addr !== 4'd4) begin n_fail++; $display("FAIL pend_trig_addr got=%0d exp=4", trig_addr); end
    guard = 0;
    while (dbg_state == POSTTRIG && guard < 64) begin step(); guard++; end
    n_checks++; if (capture_done !== 1'b1) begin n_fail++; $display("FAIL pend_done got=%b exp=1", capture_done); end
    n_checks++; if (waddr !== 4'd8) begin n_fail++; $display("FAIL pend_final_addr got=%0d exp=8", waddr); end
  endtask

  task automatic test_stop();
    int guard;
    trig_pos = 4'd5; smpl_en = 1'b1; run = 1'b1;
    step();
    run = 1'b0;
    guard = 0;
    while (dbg_state != POSTTRIG && guard < 64) begin step(); guard++; end
    n_checks++; if (dbg_state !== POSTTRIG) begin n_fail++; $display("FAIL stop_reach_post got=%0d exp=%0d", dbg_state, POSTTRIG); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL stop_idle got=%0d exp=%0d", dbg_state, IDLE); end
    n_checks++; if (we !== 1'b0 || armed !== 1'b0 || triggered !== 1'b0) begin
      n_fail++; $display("FAIL stop_outs got=%b%b%b exp=000", we, armed, triggered);
    end
    n_checks++; if (capture_done !== 1'b0) begin n_fail++; $display("FAIL stop_done got=%b exp=0", capture_done); end
    stop = 1'b1; run = 1'b1;
    step();
    stop = 1'b0; run = 1'b0;
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL stop_run_idle got=%0d exp=%0d", dbg_state, IDLE); end
    n_checks++; if (capture_done !== 1'b0) begin n_fail++; $display("FAIL stop_run_done got=%b exp=0", capture_done); end
    run = 1'b1;
    step();
    run = 1'b0;
    n_checks++; if (dbg_state !== PRETRIG || waddr !== 4'd0) begin
      n_fail++; $display("FAIL restart got=%0d/%0d exp=%0d/0", dbg_state, waddr, PRETRIG);
    end
    guard = 0;
    while (dbg_state != DONE && guard < 64) begin step(); guard++; end
    n_checks++; if (capture_done !== 1'b1) begin n_fail++; $display("FAIL restart_done got=%b exp=1", capture_done); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++; if (capture_done !== 1'b1 || triggered !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL stop_in_done got=%b/%b/%0d exp=1/0/%0d", capture_done, triggered, dbg_state, IDLE);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_trig_pos0();
    test_trig_pos15();
    test_pending_trigger();
    test_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
